slave_arbiter: RTL and testbench
================================

# slave_arbiter

Per-slave round-robin arbiter in the cross-bar, directly upstream of `slave_mux`. Collects the requests of all masters addressed to one slave, picks a single winner, and drives the one-hot `granted_master` vector consumed by `slave_mux` and the master demuxes. Holds the grant for the whole session until `slave_mux` pulses `session_is_finished`, then rotates priority. An optional watchdog aborts sessions that never finish.

## Interface

- `QTY_OF_DEVICES`, 4: number of masters; width of request and grant vectors; must be ≥2.
- `TIMEOUT_CYCLES`, 256: watchdog limit in cycles; used only with `SLAVE_ARBITER_TIMEOUT_EN`; must be ≥2.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `master_req` in QTY_OF_DEVICES: bit i = master i requests this slave (req and address decode already combined upstream).
- `session_is_finished` in 1: one-cycle pulse from `slave_mux` marking the end of the current session.
- `granted_master` out QTY_OF_DEVICES: one-hot grant, or all-zero when idle.
- `arb_busy` out 1: high while a grant is held (state BUSY).
- `timeout_err` out 1: one-cycle pulse when the watchdog aborts a session.

## Operation

- State: FSM {IDLE, BUSY}; `grant_q` (one-hot register); `ptr` (round-robin pointer, $clog2(QTY_OF_DEVICES) bits); `wd_cnt` (watchdog counter, $clog2(TIMEOUT_CYCLES) bits).
- Reset values: state IDLE, `grant_q`=0, `ptr`=0, `wd_cnt`=0. All outputs read 0: `granted_master`, `arb_busy`, `timeout_err`.
- IDLE, `|master_req`=1:
  - Search indices ptr, ptr+1, … mod QTY_OF_DEVICES; the first set bit wins.
  - `grant_q` <= onehot(winner), `wd_cnt` <= 0, go to BUSY.
- IDLE, `master_req`=0: stay.
- IDLE, `session_is_finished`=1: ignored.
- BUSY:
  - `grant_q` is held regardless of `master_req`. A request drop mid-session does not release the grant; `slave_mux` owns session termination.
  - On `session_is_finished`=1: `grant_q` <= 0, `ptr` <= (winner+1) mod QTY_OF_DEVICES, go to IDLE.
- Output mask: `granted_master` = `grant_q` & ~{QTY{session_is_finished}}.
  - Combinational, so the grant is already zero in the cycle `slave_mux` re-enters its request-waiting state. This prevents a spurious second session.
- `arb_busy` = (state == BUSY).
- Pointer wrap: winner QTY-1 → `ptr`=0.
- Reset mid-session: the next edge forces the reset values. Any in-flight session is abandoned.

## Timing

- Grant latency: 1 cycle. A request sampled in IDLE at edge N gives `granted_master` valid after edge N.
- Release: `granted_master` drops combinationally in the `session_is_finished` cycle. `grant_q` clears at the following edge.
- Minimum gap between consecutive sessions: exactly one IDLE cycle. Back-to-back sessions never get the same-cycle handover.
- Throughput with continuous requests: one grant per (session length + 1 IDLE cycle).
- The same winner is regranted only if no other master requests at the next IDLE evaluation.

## Configuration

- Macro: `SLAVE_ARBITER_TIMEOUT_EN`.
- Defined:
  - `wd_cnt` increments each BUSY cycle without `session_is_finished`.
  - If `wd_cnt` == TIMEOUT_CYCLES-1 and `session_is_finished`=0, the session is aborted at that edge: `grant_q` <= 0, `ptr` <= winner+1, go to IDLE, and `timeout_err` pulses high for the next cycle only.
  - The grant is therefore visible for exactly TIMEOUT_CYCLES cycles.
  - If finish and timeout occur in the same cycle, finish wins and `timeout_err` stays 0.
- Undefined: no counter logic; `timeout_err` is tied to 0; the grant is held indefinitely until finish.

## Test plan

- Reset: `rst`=1 for 2 cycles with `master_req`=4'b1111 → `granted_master`=0, `arb_busy`=0. At the first edge after release, `granted_master`=4'b0001.
- Rotation: `master_req`=4'b1111 held; finish pulsed 3 cycles after each grant → grants 0001, 0010, 0100, 1000, 0001, each separated by one all-zero IDLE cycle.
- Skip and wrap: `ptr`=1, `master_req`=4'b1001 → grant 4'b1000. After finish, `ptr`=0 and the next grant is 4'b0001.
- Mask and hold:
  - Grant 0100 active, `master_req` drops to 0 → grant stays 0100.
  - On the `session_is_finished` cycle, `granted_master`=0 in that same cycle. Finish while IDLE leaves all state unchanged.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - Grant 0010 with no finish → grant high 8 cycles, then 0; `timeout_err`=1 for exactly 1 cycle; next grant goes to master 2 if requesting.
  - Finish in cycle 8 → no error.
- Reset mid-session: `rst` asserted during grant 1000 → `granted_master`=0 and `ptr`=0 after the edge. After release, with `master_req`=4'b1010, the grant is 4'b0010.

Source files
------------

// File: rtl/slave_arbiter.sv
// Per-slave round-robin arbiter: one-hot session grant held until slave_mux signals finish.
// Optional session watchdog enabled by defining SLAVE_ARBITER_TIMEOUT_EN.
module slave_arbiter #(
  parameter int QTY_OF_DEVICES = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [QTY_OF_DEVICES-1:0] master_req,
  input  logic                      session_is_finished,
  output logic [QTY_OF_DEVICES-1:0] granted_master,
  output logic                      arb_busy,
  output logic                      timeout_err
);

  localparam int PW = $clog2(QTY_OF_DEVICES);

  if (QTY_OF_DEVICES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("slave_arbiter: QTY_OF_DEVICES and TIMEOUT_CYCLES must both be >= 2");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                    state_q;
  logic [QTY_OF_DEVICES-1:0] grant_q;
  logic [PW-1:0]             ptr_q;
  logic [PW-1:0]             win_q;
  logic                      timeout_err_q;

  logic                      found_d;
  logic [PW-1:0]             win_idx_d;
  logic [QTY_OF_DEVICES-1:0] grant_onehot_d;
  logic [PW-1:0]             ptr_next_d;
  logic [PW:0]               sum_d;
  logic [PW-1:0]             idx_d;

`ifdef SLAVE_ARBITER_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WW-1:0] wd_cnt_q;
`endif

  // Round-robin search starting at ptr_q; sum never exceeds 2*QTY-2 so PW+1 bits suffice.
  always_comb begin
    found_d   = 1'b0;
    win_idx_d = '0;
    sum_d     = '0;
    idx_d     = '0;
    for (int off = 0; off < QTY_OF_DEVICES; off++) begin
      sum_d = {1'b0, ptr_q} + (PW+1)'(off);
      if (sum_d >= (PW+1)'(QTY_OF_DEVICES)) begin
        sum_d = sum_d - (PW+1)'(QTY_OF_DEVICES);
      end else begin
        sum_d = sum_d;
      end
      idx_d = sum_d[PW-1:0];
      if (!found_d && master_req[idx_d]) begin
        found_d   = 1'b1;
        win_idx_d = idx_d;
      end else begin
        found_d   = found_d;
      end
    end
  end

  // Winner decode and post-session pointer advance (wraps at QTY-1).
  always_comb begin
    grant_onehot_d = QTY_OF_DEVICES'(1) << win_idx_d;
    if (win_q == PW'(QTY_OF_DEVICES - 1)) begin
      ptr_next_d = '0;
    end else begin
      ptr_next_d = win_q + PW'(1);
    end
  end

  // Arbitration FSM with session hold, release and optional watchdog abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      win_q         <= '0;
      timeout_err_q <= 1'b0;
`ifdef SLAVE_ARBITER_TIMEOUT_EN
      wd_cnt_q      <= '0;
`endif
    end else begin
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= grant_onehot_d;
            win_q   <= win_idx_d;
            state_q <= BUSY;
`ifdef SLAVE_ARBITER_TIMEOUT_EN
            wd_cnt_q <= '0;
`endif
          end
        end
        BUSY: begin
          if (session_is_finished) begin
            grant_q <= '0;
            ptr_q   <= ptr_next_d;
            state_q <= IDLE;
`ifdef SLAVE_ARBITER_TIMEOUT_EN
          end else if (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
            grant_q       <= '0;
            ptr_q         <= ptr_next_d;
            state_q       <= IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Finish masks the grant in the same cycle so slave_mux never sees a stale owner.
  assign granted_master = grant_q & ~{QTY_OF_DEVICES{session_is_finished}};
  assign arb_busy       = (state_q == BUSY);
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed self-checking bench for slave_arbiter (QTY_OF_DEVICES=4, TIMEOUT_CYCLES=8).
module tb_slave_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] master_req = 4'b0000;
  logic       session_is_finished = 1'b0;
  logic [3:0] granted_master;
  logic       arb_busy;
  logic       timeout_err;

  int vectors = 0;
  int errors  = 0;

  slave_arbiter #(.QTY_OF_DEVICES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .master_req          (master_req),
    .session_is_finished (session_is_finished),
    .granted_master      (granted_master),
    .arb_busy            (arb_busy),
    .timeout_err         (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; master_req = 4'b1111; session_is_finished = 1'b0;
    tick(); tick();
    vectors++;
    if (granted_master !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", granted_master, 4'b0000); end
    vectors++;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", arb_busy); end
    vectors++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
    rst = 1'b0;
    tick();
    vectors++;
    if (granted_master !== 4'b0001) begin errors++; $display("FAIL first_grant got=%b exp=%b", granted_master, 4'b0001); end
    vectors++;
    if (arb_busy !== 1'b1) begin errors++; $display("FAIL first_busy got=%b exp=1", arb_busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      vectors++;
      if (granted_master !== exp) begin errors++; $display("FAIL rot_grant[%0d] got=%b exp=%b", k, granted_master, exp); end
      tick(); tick();
      session_is_finished = 1'b1;
      #1;
      vectors++;
      if (granted_master !== 4'b0000) begin errors++; $display("FAIL rot_mask[%0d] got=%b exp=0000", k, granted_master); end
      tick();
      session_is_finished = 1'b0;
      vectors++;
      if (granted_master !== 4'b0000 || arb_busy !== 1'b0) begin
        errors++; $display("FAIL rot_idle[%0d] got grant=%b busy=%b exp grant=0000 busy=0", k, granted_master, arb_busy);
      end
      tick();
    end
    // sixth session (master 1) now active
    vectors++;
    if (granted_master !== 4'b0010) begin errors++; $display("FAIL rot_grant[5] got=%b exp=0010", granted_master); end
  endtask

  task automatic test_skip_wrap();
    master_req = 4'b0000;
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
    rst = 1'b1; master_req = 4'b0001; tick(); rst = 1'b0;
    tick();
    vectors++;
    if (granted_master !== 4'b0001) begin errors++; $display("FAIL skip_setup got=%b exp=0001", granted_master); end
    master_req = 4'b1001;
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
    vectors++;
    if (granted_master !== 4'b0000) begin errors++; $display("FAIL skip_gap got=%b exp=0000", granted_master); end
    tick();
    vectors++;
    if (granted_master !== 4'b1000) begin errors++; $display("FAIL skip_grant got=%b exp=1000", granted_master); end
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
    tick();
    vectors++;
    if (granted_master !== 4'b0001) begin errors++; $display("FAIL wrap_grant got=%b exp=0001", granted_master); end
    master_req = 4'b0000;
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
  endtask

  task automatic test_mask_hold();
    // ptr is 1 here
    master_req = 4'b0100; tick();
    vectors++;
    if (granted_master !== 4'b0100) begin errors++; $display("FAIL hold_grant got=%b exp=0100", granted_master); end
    master_req = 4'b0000;
    tick(); tick(); tick();
    vectors++;
    if (granted_master !== 4'b0100 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL hold_drop got grant=%b busy=%b exp grant=0100 busy=1", granted_master, arb_busy);
    end
    session_is_finished = 1'b1; #1;
    vectors++;
    if (granted_master !== 4'b0000 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL mask_same_cycle got grant=%b busy=%b exp grant=0000 busy=1", granted_master, arb_busy);
    end
    tick(); session_is_finished = 1'b0;
    vectors++;
    if (granted_master !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL mask_release got grant=%b busy=%b exp grant=0000 busy=0", granted_master, arb_busy);
    end
    session_is_finished = 1'b1; tick(); tick(); session_is_finished = 1'b0;
    vectors++;
    if (granted_master !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL idle_finish got grant=%b busy=%b exp grant=0000 busy=0", granted_master, arb_busy);
    end
    // ptr must still be 3 after the ignored finish
    master_req = 4'b1111; tick();
    vectors++;
    if (granted_master !== 4'b1000) begin errors++; $display("FAIL idle_finish_ptr got=%b exp=1000", granted_master); end
    master_req = 4'b0000;
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
  endtask

  task automatic test_timeout();
    // ptr is 0 here
    master_req = 4'b0010; tick();
`ifdef SLAVE_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (granted_master !== 4'b0010 || timeout_err !== 1'b0) begin
        errors++; $display("FAIL to_hold[%0d] got grant=%b terr=%b exp grant=0010 terr=0", i, granted_master, timeout_err);
      end
      tick();
    end
    vectors++;
    if (granted_master !== 4'b0000 || timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL to_abort got grant=%b terr=%b busy=%b exp 0000/1/0", granted_master, timeout_err, arb_busy);
    end
    master_req = 4'b0110; tick();
    vectors++;
    if (granted_master !== 4'b0100 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_next got grant=%b terr=%b exp grant=0100 terr=0", granted_master, timeout_err);
    end
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (granted_master !== 4'b0100) begin errors++; $display("FAIL fin8_hold[%0d] got=%b exp=0100", i, granted_master); end
      tick();
    end
    session_is_finished = 1'b1; #1;
    vectors++;
    if (granted_master !== 4'b0000) begin errors++; $display("FAIL fin8_mask got=%b exp=0000", granted_master); end
    tick(); session_is_finished = 1'b0; master_req = 4'b0000;
    vectors++;
    if (timeout_err !== 1'b0 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL fin8_noerr got terr=%b busy=%b exp 0/0", timeout_err, arb_busy);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL fin8_noerr2 got=%b exp=0", timeout_err); end
`else
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (granted_master !== 4'b0010 || timeout_err !== 1'b0) begin
        errors++; $display("FAIL nowd_hold[%0d] got grant=%b terr=%b exp grant=0010 terr=0", i, granted_master, timeout_err);
      end
      tick();
    end
    master_req = 4'b0000;
    session_is_finished = 1'b1; tick(); session_is_finished = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    master_req = 4'b1000; tick();
    vectors++;
    if (granted_master !== 4'b1000) begin errors++; $display("FAIL rmid_grant got=%b exp=1000", granted_master); end
    rst = 1'b1; master_req = 4'b1010; tick();
    vectors++;
    if (granted_master !== 4'b0000 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL rmid_reset got grant=%b busy=%b exp 0000/0", granted_master, arb_busy);
    end
    rst = 1'b0; tick();
    vectors++;
    if (granted_master !== 4'b0010) begin errors++; $display("FAIL rmid_after got=%b exp=0010", granted_master); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_mask_hold();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
